// File: rtl/intersection_scheduler_if.sv
// Intersection scheduler port bundle: road/pedestrian demand in, lamp and phase state out.
// master drives the demand inputs; slave is the scheduler that drives lamps and phase.
interface intersection_scheduler_if;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       ped_walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output ns_req, ew_req, ped_req,
        input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        input  ped_walk, ped_ack, phase
    );

    modport slave (
        input  ns_req, ew_req, ped_req,
        output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        output ped_walk, ped_ack, phase
    );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-road traffic light scheduler with optional pedestrian walk phase (macro PED_WALK_EN).
// Latency: lamps/phase are flops, updated one cycle after the deciding input sample.
// Backpressure: none; demand inputs are levels sampled every cycle and never stalled.
module intersection_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    intersection_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        ALL_RED = 3'd0,
        NS_G    = 3'd1,
        NS_Y    = 3'd2,
        EW_G    = 3'd3,
        EW_Y    = 3'd4,
        WALK    = 3'd5
    } state_t;

    localparam logic [7:0] GMIN_C   = 8'(GREEN_MIN - 1);
    localparam logic [7:0] GMAX_C   = 8'(GREEN_MAX - 1);
    localparam logic [7:0] YELLOW_C = 8'(YELLOW_T - 1);
    localparam logic [7:0] ALLRED_C = 8'(ALLRED_T - 1);
    localparam logic [7:0] WALK_C   = 8'(WALK_T - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       next_ew, next_ew_nx;
    logic       ped_pending;

    function automatic logic green_exit(input logic [7:0] c, input logic own, input logic other);
        return (c >= GMIN_C) && other && (!own || (c >= GMAX_C));
    endfunction

    always_comb begin
        state_nx   = state;
        next_ew_nx = next_ew;
        case (state)
            ALL_RED: if (cnt == ALLRED_C) begin
                if (ped_pending)  state_nx = WALK;
                else if (next_ew) state_nx = EW_G;
                else              state_nx = NS_G;
            end
            NS_G: if (green_exit(cnt, bus.ns_req, bus.ew_req | ped_pending)) state_nx = NS_Y;
            EW_G: if (green_exit(cnt, bus.ew_req, bus.ns_req | ped_pending)) state_nx = EW_Y;
            NS_Y, EW_Y: if (cnt == YELLOW_C) begin
                state_nx   = ALL_RED;
                next_ew_nx = ~next_ew;
            end
            WALK: if (cnt == WALK_C) state_nx = ALL_RED;
            default: state_nx = ALL_RED;
        endcase

        // Green may dwell indefinitely, so its counter parks at the max-green threshold.
        if (state_nx != state)
            cnt_nx = '0;
        else if ((state == NS_G || state == EW_G) && cnt >= GMAX_C)
            cnt_nx = cnt;
        else
            cnt_nx = cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ALL_RED;
            cnt     <= '0;
            next_ew <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            next_ew <= next_ew_nx;
        end
    end

`ifdef PED_WALK_EN
    logic ped_q;
    logic ped_ack_r;
    logic ped_rise;

    assign ped_rise    = bus.ped_req & ~ped_q;
    assign bus.ped_ack = ped_ack_r;

    // A press in the ALL_RED cycle that enters WALK is already covered by the pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_q       <= 1'b0;
            ped_pending <= 1'b0;
            ped_ack_r   <= 1'b0;
        end else begin
            ped_q     <= bus.ped_req;
            ped_ack_r <= 1'b0;
            if (state_nx == WALK && state != WALK) begin
                ped_pending <= 1'b0;
            end else if (ped_rise && !ped_pending && state != WALK) begin
                ped_pending <= 1'b1;
                ped_ack_r   <= 1'b1;
            end
        end
    end
`else
    assign ped_pending = 1'b0;
    assign bus.ped_ack = 1'b0;
`endif

    // Lamps are registered from the next state so they track the state flop exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ns_red    <= 1'b1;
            bus.ns_yellow <= 1'b0;
            bus.ns_green  <= 1'b0;
            bus.ew_red    <= 1'b1;
            bus.ew_yellow <= 1'b0;
            bus.ew_green  <= 1'b0;
            bus.ped_walk  <= 1'b0;
            bus.phase     <= 3'd0;
        end else begin
            bus.ns_green  <= (state_nx == NS_G);
            bus.ns_yellow <= (state_nx == NS_Y);
            bus.ns_red    <= !(state_nx == NS_G || state_nx == NS_Y);
            bus.ew_green  <= (state_nx == EW_G);
            bus.ew_yellow <= (state_nx == EW_Y);
            bus.ew_red    <= !(state_nx == EW_G || state_nx == EW_Y);
            bus.ped_walk  <= (state_nx == WALK);
            bus.phase     <= state_nx;
        end
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench: stimulus queues expected phase segments and ack counts; a negedge
// monitor run-length encodes phase, checks lamp decode, and pops/compares each segment.
module tb_intersection_scheduler;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    intersection_scheduler_if bus();

    intersection_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] ph;
        int         len;
    } seg_t;

    seg_t       seg_q[$];
    int         ack_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         ack_cnt  = 0;
    int         cur_len  = 0;
    logic [2:0] cur_ph   = 3'd0;
    bit         done     = 1'b0;
    bit         reported = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic emit_segment();
        seg_t e;
        if (seg_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_segment: got phase %0d len %0d, expected none", cur_ph, cur_len);
        end else begin
            e = seg_q.pop_front();
            chk("seg_phase", int'(cur_ph), int'(e.ph));
            chk("seg_len", cur_len, e.len);
        end
    endtask

    task automatic flush_ack();
        if (ack_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ack_expect: got %0d acks, expected no scenario", ack_cnt);
        end else begin
            chk("ped_ack_count", ack_cnt, ack_q.pop_front());
        end
        ack_cnt = 0;
    endtask

    always @(negedge clk) begin
        logic [6:0] lamps;
        logic [6:0] exp_lamps;
        lamps = {bus.ns_red, bus.ns_yellow, bus.ns_green,
                 bus.ew_red, bus.ew_yellow, bus.ew_green, bus.ped_walk};
        if (done && !reported) begin
            reported = 1'b1;
            chk("segments_left", seg_q.size(), 0);
            chk("ack_expect_left", ack_q.size(), 0);
        end
        if (reset) begin
            if (cur_len > 0) begin
                emit_segment();
                flush_ack();
                cur_len = 0;
            end
            chk("reset_lamps", int'(lamps), int'(7'b1001000));
            chk("reset_ack", int'(bus.ped_ack), 0);
            chk("reset_phase", int'(bus.phase), 0);
        end else begin
            case (bus.phase)
                3'd0:    exp_lamps = 7'b1001000;
                3'd1:    exp_lamps = 7'b0011000;
                3'd2:    exp_lamps = 7'b0101000;
                3'd3:    exp_lamps = 7'b1000010;
                3'd4:    exp_lamps = 7'b1000100;
                3'd5:    exp_lamps = 7'b1001001;
                default: exp_lamps = 7'b0000000;
            endcase
            chk("lamp_decode", int'(lamps), int'(exp_lamps));
            if (bus.ped_ack) ack_cnt++;
            if (cur_len > 0 && bus.phase == cur_ph) begin
                cur_len++;
            end else begin
                if (cur_len > 0) emit_segment();
                cur_ph  = bus.phase;
                cur_len = 1;
            end
        end
    end

    task automatic edge_n(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [2:0] ph, input int len);
        seg_t e;
        e.ph  = ph;
        e.len = len;
        seg_q.push_back(e);
    endtask

    initial begin
        bus.ns_req  = 1'b0;
        bus.ew_req  = 1'b0;
        bus.ped_req = 1'b0;
        edge_n(3);

        // Reset asserted during NS_Y.
        bus.ew_req = 1'b1;
        push(3'd0, 1); push(3'd1, 4); push(3'd2, 1);
        ack_q.push_back(0);
        reset = 1'b0;
        edge_n(6);
        reset = 1'b1;
        edge_n(2);

        // Restart: min green with only cross demand, then EW green holds.
        push(3'd0, 1); push(3'd1, 4); push(3'd2, 2); push(3'd0, 1); push(3'd3, 12);
        ack_q.push_back(0);
        reset = 1'b0;
        edge_n(20);
        reset = 1'b1;
        edge_n(2);

        // Both roads demanding: max green alternation.
        bus.ns_req = 1'b1;
        bus.ew_req = 1'b1;
        push(3'd0, 1); push(3'd1, 10); push(3'd2, 2); push(3'd0, 1); push(3'd3, 10);
        push(3'd4, 2); push(3'd0, 1); push(3'd1, 10); push(3'd2, 2); push(3'd0, 1);
        push(3'd3, 5);
        ack_q.push_back(0);
        reset = 1'b0;
        edge_n(45);
        reset = 1'b1;
        edge_n(2);

        bus.ns_req = 1'b0;
        bus.ew_req = 1'b0;
`ifdef PED_WALK_EN
        // Single press at NS_G count 1.
        push(3'd0, 1); push(3'd1, 4); push(3'd2, 2); push(3'd0, 1); push(3'd5, 3);
        push(3'd0, 1); push(3'd3, 8);
        ack_q.push_back(1);
        reset = 1'b0;
        edge_n(2);  bus.ped_req = 1'b1;
        edge_n(1);  bus.ped_req = 1'b0;
        edge_n(17);
        reset = 1'b1;
        edge_n(2);

        // Repeat press while pending, presses in first and final WALK cycles.
        push(3'd0, 1); push(3'd1, 4); push(3'd2, 2); push(3'd0, 1); push(3'd5, 3);
        push(3'd0, 1); push(3'd3, 8);
        ack_q.push_back(1);
        reset = 1'b0;
        edge_n(2);  bus.ped_req = 1'b1;
        edge_n(1);  bus.ped_req = 1'b0;
        edge_n(1);  bus.ped_req = 1'b1;
        edge_n(1);  bus.ped_req = 1'b0;
        edge_n(3);  bus.ped_req = 1'b1;
        edge_n(1);  bus.ped_req = 1'b0;
        edge_n(1);  bus.ped_req = 1'b1;
        edge_n(1);  bus.ped_req = 1'b0;
        edge_n(9);
        reset = 1'b1;
        edge_n(2);
`else
        // Pedestrian button toggling has no effect: NS green holds.
        push(3'd0, 1); push(3'd1, 29);
        ack_q.push_back(0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            edge_n(1);
            bus.ped_req = ~bus.ped_req;
        end
        reset = 1'b1;
        bus.ped_req = 1'b0;
        edge_n(2);
`endif

        done = 1'b1;
        edge_n(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green duration in cycles, legal range 1..255.
REQ-002 Parameter GREEN_MAX, default 10: maximum green duration while own-road demand persists, in cycles; must be >= GREEN_MIN and <= 255.
REQ-003 Parameter YELLOW_T, default 2: yellow duration in cycles, legal range 1..255.
REQ-004 Parameter ALLRED_T, default 1: all-red clearance duration in cycles, legal range 1..255.
REQ-005 Parameter WALK_T, default 3: pedestrian walk duration in cycles, legal range 1..255.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 ns_req  input  1  north-south vehicle demand, level, sampled every cycle.
REQ-009 ew_req  input  1  east-west vehicle demand, level, sampled every cycle.
REQ-010 ped_req  input  1  pedestrian button, one or more cycles high.
REQ-011 ns_red, ns_yellow, ns_green  output  1 each  north-south lamps, registered, exactly one high.
REQ-012 ew_red, ew_yellow, ew_green  output  1 each  east-west lamps, registered, exactly one high.
REQ-013 ped_walk  output  1  walk lamp, registered.
REQ-014 ped_ack  output  1  one-cycle pulse confirming a pedestrian request was latched.
REQ-015 phase  output  3  current state code: ALL_RED=0, NS_G=1, NS_Y=2, EW_G=3, EW_Y=4, WALK=5.

Function
REQ-016 The FSM SHALL have states ALL_RED, NS_G, NS_Y, EW_G, EW_Y and WALK; an 8-bit dwell counter SHALL clear to 0 on every state entry and increment each cycle the state is held.
REQ-017 A state of duration T SHALL occupy exactly T cycles: exit when the counter equals T-1.
REQ-018 Transitions: NS_G->NS_Y->ALL_RED and EW_G->EW_Y->ALL_RED; ALL_RED->WALK if a pedestrian request is pending, else ALL_RED->green of next_road; WALK->ALL_RED.
REQ-019 next_road SHALL toggle on each yellow exit, so it names the road opposite to the one just cleared.
REQ-020 Other-side demand is defined as the opposite road's request or a pending pedestrian request.
REQ-021 Green SHALL exit to yellow when the counter is >= GREEN_MIN-1, other-side demand is present, and either own-road request is low or the counter is >= GREEN_MAX-1.
REQ-022 With no other-side demand, green SHALL hold indefinitely.
REQ-023 The green counter SHALL saturate at GREEN_MAX-1 and never wrap.
REQ-024 A rising ped_req outside WALK SHALL set the ped_pending flag; ped_ack SHALL pulse in the cycle after the flag sets.
REQ-025 Presses while ped_pending is already set, or during WALK, SHALL be ignored and SHALL produce no ped_ack.
REQ-026 ped_pending SHALL clear on WALK entry; a press in the final WALK cycle is ignored.
REQ-027 Lamps SHALL be decoded from state: the green road shows green or yellow, and every other lamp group shows red.
REQ-028 ped_walk SHALL be high only in WALK, with both roads red.
REQ-029 Outputs SHALL reflect the new state in the cycle after a transition; there is no combinational path from inputs to outputs.

Reset
REQ-030 Reset SHALL force state ALL_RED, counter 0, next_road=NS and ped_pending=0.
REQ-031 During reset, outputs SHALL be ns_red=ew_red=1, all other lamps 0, ped_walk=0, ped_ack=0 and phase=0.
REQ-032 Assertion mid-operation, including during yellow or WALK, SHALL take effect immediately and restart the sequence as in REQ-030.

Configuration
REQ-033 With macro PED_WALK_EN defined, the pedestrian logic (ped_pending, WALK state, ped_ack) SHALL be compiled in as specified.
REQ-034 Without PED_WALK_EN, ped_req SHALL be ignored, ped_walk and ped_ack SHALL be tied 0, WALK SHALL be unreachable, and other-side demand SHALL be the opposite road's request only.

Verification (defaults, PED_WALK_EN defined unless stated)
REQ-035 Release reset, ns_req=0, ew_req=1 -> ALL_RED for 1 cycle; NS_G for 4; NS_Y for 2; ALL_RED for 1; then EW_G, with EW_G holding while ns_req=0.
REQ-036 ns_req=1 and ew_req=1 held -> each green lasts exactly 10 cycles, yellows 2, all-reds 1, alternating roads.
REQ-037 Pulse ped_req for 1 cycle at NS_G count 1, no vehicle demand -> ped_ack pulses once; NS_G exits after cycle 4; NS_Y 2; ALL_RED 1; WALK 3 with ped_walk=1; ALL_RED 1; EW_G.
REQ-038 Second ped_req while pending, and ped_req during WALK -> no ped_ack, and exactly one WALK phase.
REQ-039 Assert reset during NS_Y -> all lamps red, phase=0 and ped_walk=0 immediately; after release, sequence restarts as in REQ-035.
REQ-040 PED_WALK_EN undefined, ped_req toggling, no vehicle demand -> NS_G holds forever, ped_walk=0 and ped_ack=0 throughout.
